// File: rtl/qreg_uart_tx.sv
// qreg_uart_tx: captures bytes written to the nic8 Q register into a small FIFO
// and serialises them on tx as 8N1 (or 8E1 when QREG_UART_PARITY_EN is defined).
// The CPU never stalls: a push into a full FIFO is dropped and sets a sticky flag.
module qreg_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_CONE  = CW'(1);
  localparam logic [PW-1:0] LP_PONE  = PW'(1);
  localparam logic [TW-1:0] LP_TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] LP_TONE  = TW'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef QREG_UART_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;
  logic [2:0]    w_next_idx;

  assign w_bit_end  = (r_timer == LP_TLAST);
  assign w_head     = r_mem[r_rptr];
  assign w_next_idx = r_idx + 3'd1;
  // Space is judged on the count before the edge, so a same-edge pop never frees room.
  assign w_push     = load && (r_count < LP_DEPTH);
  assign w_pop      = (r_count != '0) &&
                      ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  assign tx       = r_tx;
  assign empty    = (r_count == '0);
  assign full     = (r_count == LP_DEPTH);
  assign busy     = (r_state != ST_IDLE);
  assign overflow = r_ovf;

  // FIFO storage: written on every accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_PONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LP_PONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CONE;
        2'b01:   r_count <= r_count - LP_CONE;
        default: r_count <= r_count;
      endcase
      if (load && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Transmitter FSM; tx is loaded with the value of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx    <= 1'b1;
          r_timer <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer + LP_TONE;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_idx == 3'd7) begin
`ifdef QREG_UART_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= ^r_shift;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx <= w_next_idx;
              r_tx  <= r_shift[w_next_idx];
            end
          end else begin
            r_timer <= r_timer + LP_TONE;
          end
        end
`ifdef QREG_UART_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_timer <= r_timer + LP_TONE;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + LP_TONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qreg_uart_tx.sv
// Directed bench for qreg_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// Frame bit counts follow QREG_UART_PARITY_EN when it is defined.
module tb_qreg_uart_tx;

  localparam int CPB = 4;
`ifdef QREG_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       load  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       tx;
  logic       empty;
  logic       full;
  logic       busy;
  logic       overflow;

  int n_tot = 0;
  int n_bad = 0;

  qreg_uart_tx #(
    .CLKS_PER_BIT(4),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data(data),
    .tx(tx),
    .empty(empty),
    .full(full),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level for frame bit k: start, 8 data bits LSB first, [even parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef QREG_UART_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks tx cycle by cycle from frame cycle 'off' to the end of the frame.
  task automatic expect_frame(input logic [7:0] b, input int off,
                              input bit ck_empty, input logic exp_empty);
    for (int c = off; c < NBITS * CPB; c++) begin
      chk($sformatf("tx_%02h_c%0d", b, c), {31'd0, tx}, {31'd0, frame_bit(b, c / CPB)});
      chk($sformatf("busy_%02h_c%0d", b, c), {31'd0, busy}, 32'd1);
      if (ck_empty) chk($sformatf("empty_%02h_c%0d", b, c), {31'd0, empty}, {31'd0, exp_empty});
      tick();
    end
  endtask

  initial begin
    logic [7:0] bv;

    // Reset values
    tick();
    tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Single byte 0x41: empty falls at the load edge, tx falls one edge later
    data = 8'h41;
    load = 1'b1;
    tick();
    load = 1'b0;
    data = 8'hFF;
    chk("lat_empty_fall", {31'd0, empty}, 32'd0);
    chk("lat_tx_still_high", {31'd0, tx}, 32'd1);
    chk("lat_busy_still_low", {31'd0, busy}, 32'd0);
    tick();
    expect_frame(8'h41, 0, 1'b1, 1'b1);
    chk("single_busy_end", {31'd0, busy}, 32'd0);
    chk("single_tx_end", {31'd0, tx}, 32'd1);

`ifdef QREG_UART_PARITY_EN
    // Odd popcount byte: parity bit must be 1
    data = 8'h43;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    expect_frame(8'h43, 0, 1'b1, 1'b1);
    chk("par_busy_end", {31'd0, busy}, 32'd0);
`endif

    // Back-to-back 0x55, 0xAA: no idle cycle between frames
    tick();
    data = 8'h55;
    load = 1'b1;
    tick();
    data = 8'hAA;
    tick();
    load = 1'b0;
    expect_frame(8'h55, 0, 1'b1, 1'b0);
    expect_frame(8'hAA, 0, 1'b1, 1'b1);
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);

    // Overflow: 0x01 to the transmitter, 0x02..0x05 fill, 0x06 dropped
    for (int i = 0; i < 6; i++) begin
      data = 8'(i + 1);
      load = 1'b1;
      tick();
      if (i == 4) begin
        chk("ovf_full_at4", {31'd0, full}, 32'd1);
        chk("ovf_flag_at4", {31'd0, overflow}, 32'd0);
      end
      if (i == 5) begin
        chk("ovf_full_at5", {31'd0, full}, 32'd1);
        chk("ovf_flag_at5", {31'd0, overflow}, 32'd1);
      end
    end
    load = 1'b0;
    expect_frame(8'h01, 4, 1'b0, 1'b0);
    expect_frame(8'h02, 0, 1'b0, 1'b0);
    expect_frame(8'h03, 0, 1'b0, 1'b0);
    expect_frame(8'h04, 0, 1'b0, 1'b0);
    expect_frame(8'h05, 0, 1'b1, 1'b1);
    chk("ovf_busy_end", {31'd0, busy}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_empty_end", {31'd0, empty}, 32'd1);

    // Wrap-around: 10 bytes, one per frame, after clearing overflow
    reset = 1'b1;
    tick();
    chk("wrap_rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bv = 8'h10 + 8'(i);
      data = bv;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      expect_frame(bv, 0, 1'b1, 1'b1);
      chk($sformatf("wrap_busy_%0d", i), {31'd0, busy}, 32'd0);
    end
    chk("wrap_ovf", {31'd0, overflow}, 32'd0);
    chk("wrap_full", {31'd0, full}, 32'd0);

    // Reset during bit 3 of 0xF0 with two bytes queued
    data = 8'hF0;
    load = 1'b1;
    tick();
    data = 8'hA1;
    tick();
    data = 8'hB2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("mid_tx_bit3", {31'd0, tx}, 32'd0);
    chk("mid_empty_queued", {31'd0, empty}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_full", {31'd0, full}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk($sformatf("post_rst_tx_%0d", i), {31'd0, tx}, 32'd1);
      chk($sformatf("post_rst_busy_%0d", i), {31'd0, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
